pipe_chain: RTL
===============

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload bits per stage.
REQ-002 Parameter DEPTH, default 4, number of stages; legal range 2..8.
REQ-003 Parameter KILL, default 2, number of youngest stages a flush invalidates; legal range 1..DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers in_data/in_halt.
REQ-007 in_data  input  WIDTH  payload.
REQ-008 in_halt  input  1  marks the offered item as a halt item.
REQ-009 in_ready  output  1  item accepted when in_valid&&in_ready.
REQ-010 out_valid  output  1  stage DEPTH-1 holds a valid item.
REQ-011 out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-012 out_ready  input  1  downstream accepts; transfer when out_valid&&out_ready.
REQ-013 flush  input  1  kill the youngest KILL stages this cycle.
REQ-014 halted  output  1  sticky; a halt item has left the output.
REQ-015 count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-016 Stage 0 is youngest (input side); stage DEPTH-1 is oldest (output); each stage holds valid v[i], payload d[i], halt tag h[i].
REQ-017 Latency SHALL be exactly DEPTH cycles from acceptance to out_valid with no stalls, flushes, or bubble collapse.
REQ-018 Global advance adv = !v[DEPTH-1] || out_ready; when adv, every stage loads from its predecessor and stage 0 loads the accepted input (v[0] = in_valid&&in_ready).
REQ-019 When !adv, all stages hold; payload of invalid stages is don't-care.
REQ-020 halt_pend = OR over i of v[i]&h[i]; in_ready SHALL be adv && !flush && !halt_pend && !halted.
REQ-021 On flush, every item occupying stages 0..KILL-1 at the start of the cycle SHALL be dropped; no input is accepted; stages >= KILL advance or hold normally, and a stage loading from a killed stage becomes invalid.
REQ-022 flush while the halt item is in a killed stage SHALL clear halt_pend, so in_ready may reassert the next cycle.
REQ-023 halted SHALL set on the cycle after a transfer whose item has h=1, and remain set until rst; flush does not clear it.
REQ-024 count SHALL equal the number of set v[i] in the current cycle, range 0..DEPTH.
REQ-025 Simultaneous output transfer and input acceptance with a full chain SHALL keep count unchanged.
REQ-026 No item SHALL be duplicated or reordered; out_data SHALL be stable while out_valid&&!out_ready.

Reset
REQ-027 On rst: all v[i]=0, h[i]=0, halted=0; hence out_valid=0, count=0, in_ready=1 the following cycle; out_data is don't-care.
REQ-028 rst SHALL override flush, input acceptance, and output transfer in the same cycle; items in flight at rst are discarded.

Configuration
REQ-029 Macro PIPE_CHAIN_COLLAPSE_EN: when defined, per-stage ready r[DEPTH-1] = !v[DEPTH-1] || out_ready, r[i] = !v[i] || r[i+1]; stage i loads when r[i]; in_ready uses r[0] in place of adv, so bubbles fill under stall.
REQ-030 Without PIPE_CHAIN_COLLAPSE_EN, the global-advance behaviour of REQ-018..REQ-019 applies and bubbles are preserved under stall.

Verification
REQ-031 Reset, then stream items 1..8 (DEPTH=4), out_ready=1 -> item 1 at out_valid on cycle 4 after acceptance, one item per cycle, count=4 steady.
REQ-032 Chain full, out_ready=0 for 3 cycles -> in_ready=0, out_data held, count=4; release -> order preserved, no loss.
REQ-033 Items A,B,C,D accepted, flush asserted with A in stage 3, B in stage 2, C in stage 1, D in stage 0, KILL=2, out_ready=1 -> outputs A, B only; count drops to 1 then 0.
REQ-034 Halt item H after items 1,2 -> in_ready=0 from the cycle after H is accepted; halted=1 the cycle after H transfers; in_ready stays 0 until rst.
REQ-035 Halt item in stage 0 plus flush (KILL=2) -> halt_pend clears, in_ready=1 the next cycle, halted never sets.
REQ-036 With PIPE_CHAIN_COLLAPSE_EN, pattern valid,bubble,valid,bubble then out_ready=0 -> two items compact to stages 3 and 2 within 2 cycles; without the macro, the bubbles remain.

Source files
------------

// File: rtl/pipe_chain_if.sv
// Stream bus for pipe_chain: upstream offer (valid/data/halt/ready) and
// downstream delivery (valid/data/ready) grouped in one interface.
interface pipe_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_halt;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Producer/consumer side: drives the offer, observes acceptance and output
    modport master (
        output in_valid, in_data, in_halt, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Pipeline side
    modport slave (
        input  in_valid, in_data, in_halt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/ready pipeline with flush of the youngest
// KILL stages and a sticky halt that blocks input once a halt item enters.
// Optional macro PIPE_CHAIN_COLLAPSE_EN switches from a global advance to
// per-stage ready so bubbles fill in while the output is stalled.

// One pipeline stage: valid, halt tag and payload.
module pipe_chain_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             kill,
    input  logic             src_v,
    input  logic [WIDTH-1:0] src_d,
    input  logic             src_h,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             h
);
    // Control state: take predecessor on load, otherwise hold unless killed
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            h <= 1'b0;
        end else if (load) begin
            v <= src_v;
            h <= src_h;
        end else begin
            v <= v && !kill;
        end
    end

    // Payload has no reset; it is only meaningful while v is set
    always_ff @(posedge clk) begin
        if (load) d <= src_d;
    end
endmodule

module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int KILL  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    pipe_chain_if.slave                bus,
    input  logic                       flush,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0]            hlt_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            kill;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0]            src_h;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic                        halt_pend;
    logic                        in_rdy;
    logic                        acc;
    logic                        xfer;

`ifdef PIPE_CHAIN_COLLAPSE_EN
    logic [DEPTH-1:0] rdy;

    // Per-stage ready: a stage can load if it is empty or its successor moves
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = !vld_pipe[DEPTH-1] || bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !vld_pipe[i] || rdy[i+1];
        end
    end

    assign load = rdy;
`else
    logic adv;

    // Whole chain moves together or not at all; bubbles keep their slot
    assign adv  = !vld_pipe[DEPTH-1] || bus.out_ready;
    assign load = {DEPTH{adv}};
`endif

    assign halt_pend = |(vld_pipe & hlt_pipe);
    assign in_rdy    = load[0] && !flush && !halt_pend && !halted;
    assign acc       = bus.in_valid && in_rdy;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_pipe[DEPTH-1];
    assign bus.out_data  = dat_pipe[DEPTH-1];
    assign xfer          = vld_pipe[DEPTH-1] && bus.out_ready;

    // Stage wiring: a stage loading from a killed predecessor receives a bubble
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam bit IN_KILL = (i < KILL);

        assign kill[i] = flush && IN_KILL;

        if (i == 0) begin : g_head
            assign src_v[i] = acc;
            assign src_d[i] = bus.in_data;
            assign src_h[i] = bus.in_halt;
        end else begin : g_body
            assign src_v[i] = vld_pipe[i-1] && !kill[i-1];
            assign src_d[i] = dat_pipe[i-1];
            assign src_h[i] = hlt_pipe[i-1];
        end

        pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (load[i]),
            .kill  (kill[i]),
            .src_v (src_v[i]),
            .src_d (src_d[i]),
            .src_h (src_h[i]),
            .v     (vld_pipe[i]),
            .d     (dat_pipe[i]),
            .h     (hlt_pipe[i])
        );
    end

    // Sticky halt: set once a halt-tagged item leaves; with KILL==DEPTH a
    // flushed output item that transfers in the same cycle still counts
    always_ff @(posedge clk) begin
        if (rst)                            halted <= 1'b0;
        else if (xfer && hlt_pipe[DEPTH-1]) halted <= 1'b1;
    end

    // Occupancy: population count of the stage valid bits
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld_pipe[i]);
        end
    end
endmodule
